// File: rtl/note_sequencer.sv
// note_sequencer: looping pattern step sequencer feeding synth.trig / synth.osc_count.
//
// Holds a STEPS-deep table of {half-period, gate length}. It walks the table
// at a tempo set by a prescaler (tick_div) and a per-step tick count (step_ticks).
//
// Ports
//   clk, rst     : single clock, synchronous active-high reset
//   run          : 1 = play the loop, 0 = stop (returns to step 0)
//   tick_div     : one tick every tick_div+1 clocks
//   step_ticks   : ticks per step (0 treated as 1)
//   wr_en/wr_addr/wr_period/wr_gate : table write port, usable at any time
//   trig         : note gate to synth
//   osc_count    : oscillator half-period to synth
//   step         : index of the step currently playing
//   step_strobe  : high on the first clock of every step
module note_sequencer #(
    parameter int STEPS  = 8,
    parameter int OSC_W  = 12,
    parameter int TICK_W = 16,
    localparam int AW    = $clog2(STEPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [TICK_W-1:0] tick_div,
    input  logic [7:0]        step_ticks,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [OSC_W-1:0]  wr_period,
    input  logic [7:0]        wr_gate,
    output logic              trig,
    output logic [OSC_W-1:0]  osc_count,
    output logic [AW-1:0]     step,
    output logic              step_strobe
);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t state, state_nx;

    logic [OSC_W-1:0]  tbl_period [STEPS];
    logic [7:0]        tbl_gate   [STEPS];

    logic [TICK_W-1:0] presc;
    logic [7:0]        tcnt;       // ticks elapsed in the current step
    logic [7:0]        cur_gate;   // gate of the playing step, 0 for a rest
    logic              pend;       // retrigger gap in progress: raise trig next clock

    // control decode
    logic              tick;
    logic              last_tick;
    logic              gate_end;
    logic              do_start;
    logic              do_adv;
    logic              load;
    logic [AW-1:0]     load_idx;
    logic [OSC_W-1:0]  ld_period;
    logic [7:0]        ld_gate;
    logic              ld_gated;

    // ---------------- state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // ---------------- next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (run)  state_nx = PLAY;
            PLAY:    if (!run) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- control decode
    // Compares use >= so that lowering tick_div / step_ticks mid-count ends the
    // current interval at once instead of running the counter round its range.
    always_comb begin
        tick      = (presc >= tick_div);
        last_tick = (step_ticks == 8'd0) ? 1'b1 : (tcnt >= step_ticks - 8'd1);
        gate_end  = tick && (cur_gate != 8'd0) &&
                    ({1'b0, tcnt} + 9'd1 == {1'b0, cur_gate});
        do_start  = (state == IDLE) && run;
        do_adv    = (state == PLAY) && run && tick && last_tick;
        load      = do_start || do_adv;
        load_idx  = do_start ? '0 : step + AW'(1);
        // Table read uses the pre-write contents, so a same-clock write to the
        // entry being loaded is not seen by this load.
        ld_period = tbl_period[load_idx];
        ld_gate   = tbl_gate[load_idx];
        ld_gated  = (ld_period != '0) && (ld_gate != 8'd0);
    end

    // ---------------- datapath / registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STEPS; i++) begin
                tbl_period[i] <= '0;
                tbl_gate[i]   <= '0;
            end
            trig        <= 1'b0;
            osc_count   <= '0;
            step        <= '0;
            step_strobe <= 1'b0;
            presc       <= '0;
            tcnt        <= '0;
            cur_gate    <= '0;
            pend        <= 1'b0;
        end else begin
            if (wr_en) begin
                tbl_period[wr_addr] <= wr_period;
                tbl_gate[wr_addr]   <= wr_gate;
            end

            step_strobe <= 1'b0;

            if (load) begin
                step        <= load_idx;
                step_strobe <= 1'b1;
                presc       <= '0;
                tcnt        <= '0;
                if (ld_gated) begin
                    osc_count <= ld_period;
                    cur_gate  <= ld_gate;
                    // If trig was high at the boundary, hold it low one clock
                    // so synth's envelope sees a fresh rising edge.
                    trig      <= !trig;
                    pend      <= trig;
                end else begin
                    cur_gate  <= '0;
                    trig      <= 1'b0;
                    pend      <= 1'b0;
                end
            end else if (state == PLAY && run) begin
                presc <= tick ? '0 : presc + TICK_W'(1);
                if (tick) tcnt <= tcnt + 8'd1;
                // Gate end wins over a pending rise: gate timing is measured
                // from step start regardless of the retrigger gap.
                if (gate_end) begin
                    trig <= 1'b0;
                    pend <= 1'b0;
                end else if (pend) begin
                    trig <= 1'b1;
                    pend <= 1'b0;
                end
            end else begin
                // idle, or stopping this clock; osc_count holds
                trig     <= 1'b0;
                step     <= '0;
                presc    <= '0;
                tcnt     <= '0;
                cur_gate <= '0;
                pend     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [15:0] tick_div;
    logic [7:0]  step_ticks;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [11:0] wr_period;
    logic [7:0]  wr_gate;
    logic        trig;
    logic [11:0] osc_count;
    logic [2:0]  step;
    logic        step_strobe;

    int checks = 0;
    int errors = 0;

    note_sequencer #(.STEPS(8), .OSC_W(12), .TICK_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .tick_div   (tick_div),
        .step_ticks (step_ticks),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_period  (wr_period),
        .wr_gate    (wr_gate),
        .trig       (trig),
        .osc_count  (osc_count),
        .step       (step),
        .step_strobe(step_strobe)
    );

    always #5 clk = ~clk;

    // observed vector layout: {trig, step_strobe, step[2:0], osc_count[11:0]}

    task automatic do_write(input logic [2:0] a, input logic [11:0] p, input logic [7:0] g);
        wr_en = 1'b1; wr_addr = a; wr_period = p; wr_gate = g;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [16:0] o;
        rst = 1'b1; run = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_period = '0; wr_gate = '0;
        tick_div = 16'd3; step_ticks = 8'd4;
        @(negedge clk);
        @(negedge clk);
        o = {trig, step_strobe, step, osc_count};
        checks++;
        if (o !== 17'd0) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", o, 17'd0);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        o = {trig, step_strobe, step, osc_count};
        checks++;
        if (o !== 17'd0) begin
            errors++;
            $display("FAIL idle_hold got=%h want=%h", o, 17'd0);
        end
    endtask

    // Steps 0..15 fully plus the first 3 clocks of step 16 (16 clocks/step).
    // Covers basic gate, retrigger gap, rest, wrap, write during the playing
    // step, and a write colliding with the load of the same entry.
    task automatic test_basic();
        logic [16:0] o, e;
        int k, c, lo, hi, ov;
        do_write(3'd0, 12'd2, 8'd2);
        do_write(3'd1, 12'd5, 8'd4);
        do_write(3'd2, 12'd5, 8'd4);
        do_write(3'd3, 12'd0, 8'd3);
        run = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 16*16 + 3; n++) begin
            @(negedge clk);
            k = n / 16; c = n % 16;
            if (k == 16) begin
                lo = 0; hi = 3; ov = 9;           // {9,1}: 1 tick = 4 clocks
            end else begin
                case (k % 8)
                    0:       begin lo = 0; hi = 7;  ov = 2; end
                    1:       begin lo = 0; hi = 15; ov = 5; end
                    2:       begin lo = 1; hi = 15; ov = 5; end  // retrigger gap
                    default: begin lo = 1; hi = 0;  ov = 5; end  // rests hold 5
                endcase
            end
            e = {(c >= lo && c <= hi) ? 1'b1 : 1'b0, (c == 0) ? 1'b1 : 1'b0,
                 3'(k % 8), 12'(ov)};
            o = {trig, step_strobe, step, osc_count};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL basic k=%0d c=%0d got=%h want=%h", k, c, o, e);
            end
            wr_en = 1'b0;
            if (k == 8 && c == 3) begin
                wr_en = 1'b1; wr_addr = 3'd0; wr_period = 12'd9; wr_gate = 8'd1;
            end
            if (k == 15 && c == 15) begin
                wr_en = 1'b1; wr_addr = 3'd0; wr_period = 12'd11; wr_gate = 8'd2;
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_stop_restart();
        logic [16:0] o;
        run = 1'b0;                               // mid-step, trig high
        @(negedge clk);
        o = {trig, step_strobe, step, osc_count};
        checks++;
        if (o !== {1'b0, 1'b0, 3'd0, 12'd9}) begin
            errors++;
            $display("FAIL stop got=%h want=%h", o, {1'b0, 1'b0, 3'd0, 12'd9});
        end
        @(negedge clk);
        o = {trig, step_strobe, step, osc_count};
        checks++;
        if (o !== {1'b0, 1'b0, 3'd0, 12'd9}) begin
            errors++;
            $display("FAIL stop_hold got=%h want=%h", o, {1'b0, 1'b0, 3'd0, 12'd9});
        end
        run = 1'b1;
        @(negedge clk);
        o = {trig, step_strobe, step, osc_count};
        checks++;
        if (o !== {1'b1, 1'b1, 3'd0, 12'd11}) begin
            errors++;
            $display("FAIL restart got=%h want=%h", o, {1'b1, 1'b1, 3'd0, 12'd11});
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] o;
        rst = 1'b1;                               // trig is high, run stays 1
        @(negedge clk);
        o = {trig, step_strobe, step, osc_count};
        checks++;
        if (o !== 17'd0) begin
            errors++;
            $display("FAIL reset_mid got=%h want=%h", o, 17'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        o = {trig, step_strobe, step, osc_count};
        checks++;
        if (o !== {1'b0, 1'b1, 3'd0, 12'd0}) begin
            errors++;
            $display("FAIL reset_reenter got=%h want=%h", o, {1'b0, 1'b1, 3'd0, 12'd0});
        end
    endtask

    task automatic test_degenerate();
        logic [16:0] o, e;
        run = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick_div = 16'd0; step_ticks = 8'd0;
        do_write(3'd0, 12'd3, 8'd1);
        do_write(3'd1, 12'd4, 8'd1);
        run = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            // step 1 follows a high step 0, so it spends its one clock in the gap
            e = {(n % 8 == 0) ? 1'b1 : 1'b0, 1'b1, 3'(n % 8),
                 (n % 8 == 0) ? 12'd3 : 12'd4};
            o = {trig, step_strobe, step, osc_count};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL degen n=%0d got=%h want=%h", n, o, e);
            end
        end
        run = 1'b0;
        @(negedge clk);
        o = {trig, step_strobe, step, osc_count};
        checks++;
        if (o !== {1'b0, 1'b0, 3'd0, 12'd4}) begin
            errors++;
            $display("FAIL degen_stop got=%h want=%h", o, {1'b0, 1'b0, 3'd0, 12'd4});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stop_restart();
        test_reset_mid();
        test_degenerate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
